// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller: E-stage forwarding, load-use stall, branch flush
// and a scoreboard for in-flight multi-cycle ops. Optional HAZARD_PERF_EN adds stall/flush counters.
module hazard_ctrl_sb #(
  parameter int REG_AW   = 5,
  parameter int MC_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic              McOpD,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              McStart,
  input  logic [REG_AW-1:0] McStartRd,
  input  logic              McDone,
  input  logic [REG_AW-1:0] McDoneRd,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt,
`endif
  output logic              McErr
);

  localparam int NREG = 2 ** REG_AW;
  localparam int CW   = $clog2(MC_DEPTH + 1);

  logic [NREG-1:0] pend, pend_next, done_mask, pend_src;
  logic [CW-1:0]   cnt, cnt_next;
  logic            cnt_full, cnt_empty;
  logic            lw_stall, sb_stall, inflight_hit;
  logic            start_ok, done_ok, err_now;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && Rs1E == RdM && Rs1E != '0)      ForwardAE = 2'b10;
    else if (RegWriteW && Rs1E == RdW && Rs1E != '0) ForwardAE = 2'b01;
    if (RegWriteM && Rs2E == RdM && Rs2E != '0)      ForwardBE = 2'b10;
    else if (RegWriteW && Rs2E == RdW && Rs2E != '0) ForwardBE = 2'b01;
  end

  assign cnt_full  = (cnt == CW'(MC_DEPTH));
  assign cnt_empty = (cnt == '0);
  assign lw_stall  = ResultSrcE0 && (Rs1D == RdE || Rs2D == RdE) && RdE != '0;

  // Sources being written back this cycle read the fresh value (write-first
  // register file), so they are masked out of the source check only.
  always_comb begin
    done_mask = '0;
    if (McDone) done_mask[McDoneRd] = 1'b1;
    pend_src = pend & ~done_mask;
    inflight_hit = McStart && McStartRd != '0 &&
                   (McStartRd == Rs1D || McStartRd == Rs2D ||
                    (RegWriteD && McStartRd == RdD));
    sb_stall = pend_src[Rs1D] || pend_src[Rs2D] || (RegWriteD && pend[RdD]) ||
               (McOpD && cnt_full) || inflight_hit;
  end

  assign StallF = ~PCSrcE & (lw_stall | sb_stall);
  assign StallD = StallF;
  assign FlushD = PCSrcE;
  assign FlushE = PCSrcE | lw_stall | sb_stall;

  // A start at full occupancy is dropped unless a done frees a slot the same cycle.
  always_comb begin
    start_ok = McStart && !(cnt_full && !McDone);
    done_ok  = McDone && !cnt_empty;
    err_now  = (McStart && cnt_full && !McDone) || (McDone && cnt_empty) ||
               (McDone && !pend[McDoneRd]);
    pend_next = pend & ~done_mask;
    if (start_ok && McStartRd != '0) pend_next[McStartRd] = 1'b1;
    cnt_next = cnt;
    if (start_ok && !done_ok)      cnt_next = cnt + CW'(1);
    else if (done_ok && !start_ok) cnt_next = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend  <= '0;
      cnt   <= '0;
      McErr <= 1'b0;
    end else begin
      pend  <= pend_next;
      cnt   <= cnt_next;
      McErr <= McErr | err_now;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && StallCnt != '1) StallCnt <= StallCnt + 32'd1;
      if (FlushD && FlushCnt != '1) FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed self-checking bench for hazard_ctrl_sb (REG_AW=5, MC_DEPTH=2);
// perf-counter checks compile in only when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl_sb;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, McStartRd, McDoneRd;
  logic       RegWriteD, McOpD, ResultSrcE0, PCSrcE, RegWriteM, RegWriteW;
  logic       McStart, McDone;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE, McErr;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int checkCount = 0;
  int failCount  = 0;

  hazard_ctrl_sb #(.REG_AW(5), .MC_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .McOpD(McOpD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .McStart(McStart), .McStartRd(McStartRd), .McDone(McDone), .McDoneRd(McDoneRd),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
`ifdef HAZARD_PERF_EN
    .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
    .McErr(McErr)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit past the last one.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; McOpD = 1'b0;
    Rs1E = '0; Rs2E = '0; RdE = '0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
    RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    McStart = 1'b0; McStartRd = '0; McDone = 1'b0; McDoneRd = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    applyStimulus(2);
    reset = 1'b0;
    #1;
    checkOutput("rst_fwdA", 32'(ForwardAE), 32'd0);
    checkOutput("rst_fwdB", 32'(ForwardBE), 32'd0);
    checkOutput("rst_stallF", 32'(StallF), 32'd0);
    checkOutput("rst_stallD", 32'(StallD), 32'd0);
    checkOutput("rst_flushD", 32'(FlushD), 32'd0);
    checkOutput("rst_flushE", 32'(FlushE), 32'd0);
    checkOutput("rst_err", 32'(McErr), 32'd0);

    // Forwarding priority and x0 exclusion
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
    #1 checkOutput("fwdA_M", 32'(ForwardAE), 32'd2);
    checkOutput("fwdB_none", 32'(ForwardBE), 32'd0);
    RegWriteM = 1'b0;
    #1 checkOutput("fwdA_W", 32'(ForwardAE), 32'd1);
    Rs1E = 5'd0;
    #1 checkOutput("fwdA_x0", 32'(ForwardAE), 32'd0);
    Rs2E = 5'd6; RdW = 5'd6; RdM = 5'd5; RegWriteM = 1'b1;
    #1 checkOutput("fwdB_W", 32'(ForwardBE), 32'd1);
    RdM = 5'd6;
    #1 checkOutput("fwdB_M", 32'(ForwardBE), 32'd2);
    clearInputs();

    // Load-use stall for one cycle
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    checkOutput("lw_stallF", 32'(StallF), 32'd1);
    checkOutput("lw_stallD", 32'(StallD), 32'd1);
    checkOutput("lw_flushE", 32'(FlushE), 32'd1);
    checkOutput("lw_flushD", 32'(FlushD), 32'd0);
    applyStimulus(1);
    ResultSrcE0 = 1'b0; RdE = 5'd0;
    #1;
    checkOutput("lw_after_stallD", 32'(StallD), 32'd0);
    checkOutput("lw_after_flushE", 32'(FlushE), 32'd0);
    ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    #1 checkOutput("lw_rd0_stallD", 32'(StallD), 32'd0);
    clearInputs();

    // Load-use coinciding with taken branch
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    #1;
    checkOutput("br_stallF", 32'(StallF), 32'd0);
    checkOutput("br_stallD", 32'(StallD), 32'd0);
    checkOutput("br_flushD", 32'(FlushD), 32'd1);
    checkOutput("br_flushE", 32'(FlushE), 32'd1);
    clearInputs();

    // RAW on multi-cycle rd 9: in-flight catch, pending, then done-cycle bypass
    McStart = 1'b1; McStartRd = 5'd9; Rs1D = 5'd9;
    #1 checkOutput("mc_c0_stallD", 32'(StallD), 32'd1);
    applyStimulus(1);
    McStart = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1 checkOutput($sformatf("mc_c%0d_stallD", i), 32'(StallD), 32'd1);
      applyStimulus(1);
    end
    McDone = 1'b1; McDoneRd = 5'd9;
    #1 checkOutput("mc_c6_stallD", 32'(StallD), 32'd0);
    applyStimulus(1);
    McDone = 1'b0;
    #1;
    checkOutput("mc_cleared_stallD", 32'(StallD), 32'd0);
    checkOutput("mc_noerr", 32'(McErr), 32'd0);
    clearInputs();

    // WAW on rd 12
    McStart = 1'b1; McStartRd = 5'd12;
    applyStimulus(1);
    McStart = 1'b0; RdD = 5'd12; RegWriteD = 1'b0;
    #1 checkOutput("waw_nowrite", 32'(StallD), 32'd0);
    RegWriteD = 1'b1;
    #1 checkOutput("waw_stallD", 32'(StallD), 32'd1);
    McDone = 1'b1; McDoneRd = 5'd12;
    applyStimulus(1);
    McDone = 1'b0;
    #1 checkOutput("waw_cleared", 32'(StallD), 32'd0);
    clearInputs();

    // Depth limit: two outstanding, structural stall, overflow error
    McStart = 1'b1; McStartRd = 5'd3;
    applyStimulus(1);
    McStartRd = 5'd4;
    applyStimulus(1);
    McStart = 1'b0; McOpD = 1'b1; Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd10; RegWriteD = 1'b1;
    #1;
    checkOutput("full_stallD", 32'(StallD), 32'd1);
    checkOutput("full_stallF", 32'(StallF), 32'd1);
    applyStimulus(1);
    checkOutput("full_stallD_hold", 32'(StallD), 32'd1);
    McStart = 1'b1; McStartRd = 5'd5;
    applyStimulus(1);
    McStart = 1'b0;
    #1 checkOutput("ovf_err", 32'(McErr), 32'd1);
    McOpD = 1'b0; Rs1D = 5'd5;
    #1 checkOutput("ovf_ignored", 32'(StallD), 32'd0);
    McOpD = 1'b1;
    #1 checkOutput("ovf_cnt_full", 32'(StallD), 32'd1);
    McDone = 1'b1; McDoneRd = 5'd3;
    applyStimulus(1);
    McDone = 1'b0;
    #1 checkOutput("cnt_dec_stallD", 32'(StallD), 32'd0);
    Rs1D = 5'd3;
    #1 checkOutput("rd3_cleared", 32'(StallD), 32'd0);
    Rs1D = 5'd4;
    #1 checkOutput("rd4_pending", 32'(StallD), 32'd1);
    checkOutput("err_sticky", 32'(McErr), 32'd1);

    // Mid-operation reset discards the scoreboard
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    McOpD = 1'b0;
    #1;
    checkOutput("rst_err_clr", 32'(McErr), 32'd0);
    checkOutput("rst_pend_clr", 32'(StallD), 32'd0);
    clearInputs();

    // Done with nothing outstanding is an error
    McDone = 1'b1; McDoneRd = 5'd8;
    applyStimulus(1);
    McDone = 1'b0;
    #1 checkOutput("underflow_err", 32'(McErr), 32'd1);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;

`ifdef HAZARD_PERF_EN
    #1;
    checkOutput("perf_rst_stall", StallCnt, 32'd0);
    checkOutput("perf_rst_flush", FlushCnt, 32'd0);
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    applyStimulus(3);
    clearInputs();
    PCSrcE = 1'b1;
    applyStimulus(1);
    clearInputs();
    #1;
    checkOutput("perf_stall", StallCnt, 32'd3);
    checkOutput("perf_flush", FlushCnt, 32'd1);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("perf_clr_stall", StallCnt, 32'd0);
    checkOutput("perf_clr_flush", FlushCnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
